// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC generator: default widths, the
// redirect-buffer state type and the target alignment helper.
package pc_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int ILEN_BYTES_DEF = 4;
    localparam int ADDR_SHIFT_DEF = 2;

    // Widest PC the alignment helper handles; callers cast in and out.
    localparam int PC_MAX_W = 64;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } pc_state_e;

    function automatic logic [PC_MAX_W-1:0] align_pc(
        input logic [PC_MAX_W-1:0] addr,
        input int unsigned         shift
    );
        logic [PC_MAX_W-1:0] mask;
        mask = ~((64'd1 << shift) - 64'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending-redirect buffer: stores a branch target that arrives while the
// pipeline is paused and tracks the RUN/HOLD state.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            capture,
    input  logic            release_en,
    input  logic            clear,
    input  logic [XLEN-1:0] capture_pc,
    output logic [XLEN-1:0] pend_pc,
    output logic            pend_valid
);

    pc_state_e       state_r;
    pc_state_e       state_nxt_s;
    logic [XLEN-1:0] pend_pc_r;
    logic [XLEN-1:0] pend_pc_nxt_s;
    logic            pend_valid_r;

    // Next-state and pending-target selection; clear dominates capture.
    always_comb begin
        state_nxt_s   = state_r;
        pend_pc_nxt_s = pend_pc_r;
        case (state_r)
            RUN: begin
                if (clear) begin
                    state_nxt_s   = RUN;
                    pend_pc_nxt_s = {XLEN{1'b0}};
                end else if (capture) begin
                    state_nxt_s   = HOLD;
                    pend_pc_nxt_s = capture_pc;
                end else begin
                    state_nxt_s   = RUN;
                end
            end
            HOLD: begin
                if (clear) begin
                    state_nxt_s   = RUN;
                    pend_pc_nxt_s = {XLEN{1'b0}};
                end else if (capture) begin
                    state_nxt_s   = HOLD;
                    pend_pc_nxt_s = capture_pc;
                end else if (release_en) begin
                    state_nxt_s   = RUN;
                end else begin
                    state_nxt_s   = HOLD;
                end
            end
            default: begin
                state_nxt_s   = RUN;
                pend_pc_nxt_s = {XLEN{1'b0}};
            end
        endcase
    end

    // State, stored target and the registered HOLD indication.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= RUN;
            pend_pc_r    <= {XLEN{1'b0}};
            pend_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pend_pc_r    <= pend_pc_nxt_s;
            pend_valid_r <= (state_nxt_s == HOLD);
        end
    end

    assign pend_pc    = pend_pc_r;
    assign pend_valid = pend_valid_r;

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: arbitrates trap, redirect, pending
// target, pause and sequential advance, and drives the ROM word address.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              ILEN_BYTES = ILEN_BYTES_DEF,
    parameter int              ADDR_SHIFT = ADDR_SHIFT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pause,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       trap_valid,
    input  logic [XLEN-1:0]            trap_pc,
    output logic [XLEN-1:0]            pc,
    output logic [XLEN-ADDR_SHIFT-1:0] pc_rom_addr,
    output logic                       pend_valid,
    output logic                       misalign_err
);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_nxt_s;
    logic            misalign_r;
    logic            misalign_nxt_s;
    logic [XLEN-1:0] tgt_s;
    logic [XLEN-1:0] tgt_aligned_s;
    logic            tgt_load_s;
    logic            buf_capture_s;
    logic            buf_release_s;
    logic            buf_clear_s;
    logic [XLEN-1:0] pend_pc_s;
    logic            pend_valid_s;

    // A trap or an unpaused redirect supersedes anything pending.
    assign buf_clear_s   = trap_valid | (redirect_valid & ~pause);
    assign buf_capture_s = ~trap_valid & redirect_valid & pause;
    assign buf_release_s = pend_valid_s & ~pause & ~trap_valid & ~redirect_valid;

    pc_redirect_buf #(
        .XLEN (XLEN)
    ) u_redirect_buf (
        .clk        (clk),
        .rst        (rst),
        .capture    (buf_capture_s),
        .release_en (buf_release_s),
        .clear      (buf_clear_s),
        .capture_pc (redirect_pc),
        .pend_pc    (pend_pc_s),
        .pend_valid (pend_valid_s)
    );

    // Priority selection of the target to apply this cycle, if any.
    always_comb begin
        tgt_s      = {XLEN{1'b0}};
        tgt_load_s = 1'b0;
        if (trap_valid) begin
            tgt_s      = trap_pc;
            tgt_load_s = 1'b1;
        end else if (redirect_valid && !pause) begin
            tgt_s      = redirect_pc;
            tgt_load_s = 1'b1;
        end else if (!redirect_valid && pend_valid_s && !pause) begin
            tgt_s      = pend_pc_s;
            tgt_load_s = 1'b1;
        end else begin
            tgt_load_s = 1'b0;
        end
    end

    assign tgt_aligned_s = XLEN'(align_pc(PC_MAX_W'(tgt_s), ADDR_SHIFT));

    // Next PC: applied target, hold under pause/capture, else sequential.
    always_comb begin
        pc_nxt_s       = pc_r + XLEN'(ILEN_BYTES);
        misalign_nxt_s = 1'b0;
        if (tgt_load_s) begin
            pc_nxt_s       = tgt_aligned_s;
            misalign_nxt_s = (tgt_aligned_s != tgt_s);
        end else if (pause) begin
            pc_nxt_s = pc_r;
        end else begin
            pc_nxt_s = pc_r + XLEN'(ILEN_BYTES);
        end
    end

    // PC register and one-cycle misalignment pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            misalign_r <= 1'b0;
        end else begin
            pc_r       <= pc_nxt_s;
            misalign_r <= misalign_nxt_s;
        end
    end

    assign pc           = pc_r;
    assign pc_rom_addr  = pc_r[XLEN-1:ADDR_SHIFT];
    assign pend_valid   = pend_valid_s;
    assign misalign_err = misalign_r;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        pause;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] pc;
    logic [29:0] pc_rom_addr;
    logic        pend_valid;
    logic        misalign_err;

    int tests  = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_pend_pc;
    logic        m_mis;

    pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .pause          (pause),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .pc             (pc),
        .pc_rom_addr    (pc_rom_addr),
        .pend_valid     (pend_valid),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    // Apply one clock edge and advance the model by the priority rules.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h0; m_pend = 1'b0; m_mis = 1'b0;
        end else if (trap_valid) begin
            m_pc = {trap_pc[31:2], 2'b00}; m_mis = (trap_pc[1:0] != 2'b00); m_pend = 1'b0;
        end else if (redirect_valid && !pause) begin
            m_pc = {redirect_pc[31:2], 2'b00}; m_mis = (redirect_pc[1:0] != 2'b00); m_pend = 1'b0;
        end else if (redirect_valid) begin
            m_pend = 1'b1; m_pend_pc = redirect_pc; m_mis = 1'b0;
        end else if (m_pend && !pause) begin
            m_pc = {m_pend_pc[31:2], 2'b00}; m_mis = (m_pend_pc[1:0] != 2'b00); m_pend = 1'b0;
        end else if (pause) begin
            m_mis = 1'b0;
        end else begin
            m_pc = m_pc + 32'd4; m_mis = 1'b0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        pause = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0;
        redirect_pc = 32'h0; trap_pc = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        tests++;
        if (pc !== 32'h0 || pc_rom_addr !== 30'h0 || pend_valid !== 1'b0 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: pc=%h rom=%h pend=%b mis=%b required pc=0 rom=0 pend=0 mis=0",
                     pc, pc_rom_addr, pend_valid, misalign_err);
        end
    endtask

    task automatic test_free_run();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (pc !== 32'(k * 4) || pc_rom_addr !== 30'(k)) begin
                errors++;
                $display("FAIL free_run[%0d]: pc=%h rom=%h required pc=%h rom=%h",
                         k, pc, pc_rom_addr, 32'(k * 4), 30'(k));
            end
            if (k < 3) tick();
        end
    endtask

    task automatic test_pause();
        tick();
        tests++;
        if (pc !== 32'h10) begin
            errors++; $display("FAIL pause_entry: pc=%h required 00000010", pc);
        end
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (pc !== 32'h10) begin
                errors++; $display("FAIL pause_hold[%0d]: pc=%h required 00000010", k, pc);
            end
        end
        pause = 1'b0;
        tick();
        tests++;
        if (pc !== 32'h14) begin
            errors++; $display("FAIL pause_release: pc=%h required 00000014", pc);
        end
    endtask

    task automatic test_redirect_pause();
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        tick();
        pause = 1'b1; redirect_pc = 32'h100;
        tick();
        tests++;
        if (pend_valid !== 1'b1 || pc !== 32'h10) begin
            errors++; $display("FAIL redir_capture1: pc=%h pend=%b required pc=00000010 pend=1", pc, pend_valid);
        end
        redirect_pc = 32'h200;
        tick();
        tests++;
        if (pend_valid !== 1'b1 || pc !== 32'h10) begin
            errors++; $display("FAIL redir_capture2: pc=%h pend=%b required pc=00000010 pend=1", pc, pend_valid);
        end
        redirect_valid = 1'b0; pause = 1'b0;
        tick();
        tests++;
        if (pc !== 32'h200 || pend_valid !== 1'b0) begin
            errors++; $display("FAIL redir_apply: pc=%h pend=%b required pc=00000200 pend=0", pc, pend_valid);
        end
        tick();
        tests++;
        if (pc !== 32'h204) begin
            errors++; $display("FAIL redir_next: pc=%h required 00000204", pc);
        end
    endtask

    task automatic test_trap_priority();
        pause = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
        tick();
        trap_valid = 1'b1; trap_pc = 32'h80; redirect_pc = 32'h300;
        tick();
        tests++;
        if (pc !== 32'h80 || pend_valid !== 1'b0) begin
            errors++; $display("FAIL trap_priority: pc=%h pend=%b required pc=00000080 pend=0", pc, pend_valid);
        end
        idle_inputs();
        tick();
        tests++;
        if (pc !== 32'h84 || pend_valid !== 1'b0) begin
            errors++; $display("FAIL trap_no_pending: pc=%h pend=%b required pc=00000084 pend=0", pc, pend_valid);
        end
    endtask

    task automatic test_misalign_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        tests++;
        if (pc !== 32'h100 || misalign_err !== 1'b1) begin
            errors++; $display("FAIL misalign_pulse: pc=%h mis=%b required pc=00000100 mis=1", pc, misalign_err);
        end
        redirect_valid = 1'b0;
        tick();
        tests++;
        if (pc !== 32'h104 || misalign_err !== 1'b0) begin
            errors++; $display("FAIL misalign_clear: pc=%h mis=%b required pc=00000104 mis=0", pc, misalign_err);
        end
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        tests++;
        if (pc !== 32'h0 || pc_rom_addr !== 30'h0) begin
            errors++; $display("FAIL wrap: pc=%h rom=%h required pc=00000000 rom=0", pc, pc_rom_addr);
        end
    endtask

    task automatic test_reset_hold();
        pause = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h400;
        tick();
        tests++;
        if (pend_valid !== 1'b1) begin
            errors++; $display("FAIL hold_capture: pend=%b required 1", pend_valid);
        end
        redirect_valid = 1'b0; rst = 1'b1;
        tick();
        tests++;
        if (pc !== 32'h0 || pend_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hold: pc=%h pend=%b required pc=00000000 pend=0", pc, pend_valid);
        end
        rst = 1'b0; pause = 1'b0;
        tick();
        tests++;
        if (pc !== 32'h4) begin
            errors++; $display("FAIL reset_discard: pc=%h required 00000004", pc);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst            = ($urandom_range(0, 49) == 0);
            pause          = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 3) == 0);
            trap_valid     = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom();
            trap_pc        = $urandom();
            tick();
            tests++;
            if (pc !== m_pc || pc_rom_addr !== m_pc[31:2] || pend_valid !== m_pend || misalign_err !== m_mis) begin
                errors++;
                $display("FAIL random[%0d]: pc=%h rom=%h pend=%b mis=%b required pc=%h rom=%h pend=%b mis=%b",
                         k, pc, pc_rom_addr, pend_valid, misalign_err, m_pc, m_pc[31:2], m_pend, m_mis);
            end
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    initial begin
        m_pc = 32'h0; m_pend = 1'b0; m_pend_pc = 32'h0; m_mis = 1'b0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_free_run();
        test_pause();
        test_redirect_pause();
        test_trap_priority();
        test_misalign_wrap();
        test_reset_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch program-counter generator for the five-stage core; the successor to the single-input PC register. It owns the architectural fetch PC and computes the sequential increment internally. It arbitrates trap, branch/jump redirect, pause and sequential advance, and holds a redirect that arrives while the pipeline is paused until the pause releases. It drives the word address into the separate instruction ROM, which is distinct from data RAM, so reset targets the first ROM word by default.

## Interface
- XLEN, 32, PC width in bits
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ILEN_BYTES, 4, sequential increment in bytes; power of two
- ADDR_SHIFT, 2, right shift from byte PC to ROM word address; equals log2(ILEN_BYTES)
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- pause  in  1  hazard stall; PC holds while high
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  XLEN  branch/jump target (byte address)
- trap_valid  in  1  exception/interrupt entry this cycle
- trap_pc  in  XLEN  trap vector (byte address)
- pc  out  XLEN  current fetch PC (registered)
- pc_rom_addr  out  XLEN-ADDR_SHIFT  pc >> ADDR_SHIFT (combinational from pc)
- pend_valid  out  1  a redirect is captured and waiting for pause to drop
- misalign_err  out  1  one-cycle pulse: the last applied target had nonzero bits [ADDR_SHIFT-1:0]

## Operation
- Two states: RUN and HOLD. HOLD means a pending target is stored. Reset state is RUN.
- Next-PC priority, highest first: rst > trap_valid > redirect_valid > pending target > pause > pc + ILEN_BYTES.
- trap_valid is honoured even while pause is high. It loads trap_pc, clears any pending target, and goes to RUN.
- redirect_valid with pause low loads redirect_pc and stays in or returns to RUN. This discards any older pending target.
- redirect_valid with pause high leaves pc unchanged. It captures redirect_pc into the pending register and goes to HOLD.
- A later redirect during the same pause overwrites the pending register; the latest redirect wins.
- In HOLD with pause low and no new trap or redirect: pc loads the pending target, and the state goes to RUN.
- In HOLD with pause high: pc holds and the pending target is retained.
- Every applied target (trap, redirect or pending) is aligned by clearing bits [ADDR_SHIFT-1:0].
- misalign_err is asserted the cycle after the load if any of those cleared bits were 1.
- Sequential increment wraps modulo 2^XLEN; no overflow flag.
- pc changes only on clock edges; there is no asynchronous path.

## Timing
- Reset values: pc = RESET_PC, pc_rom_addr = RESET_PC >> ADDR_SHIFT, pend_valid = 0, misalign_err = 0, state = RUN.
- Reset asserted mid-HOLD discards the pending target at that edge.
- One-cycle latency: an input sampled at edge N is visible on pc after edge N.
- pc_rom_addr follows pc in the same cycle.
- pend_valid equals (state == HOLD) and is registered.
- Simultaneous trap_valid and redirect_valid: the trap wins and the redirect is dropped.
- Simultaneous redirect_valid and pause release while in HOLD: the new redirect_pc wins over the stored target.
- pause high with nothing else: pc holds indefinitely with no bubble-insertion logic; downstream handles bubbles.

## Structure
- Shared package pc_pkg holds:
  - default XLEN, ILEN_BYTES, ADDR_SHIFT;
  - the state enum pc_state_e {RUN, HOLD};
  - an align function that clears the low ADDR_SHIFT bits.
- One sub-module, pc_redirect_buf, holds the pending-target register, pend_valid and the RUN/HOLD FSM.
  - Inputs: capture, release, clear.
  - The top level keeps the priority mux, the pc register and the misalign pulse.
- Target size: about 150–200 lines of RTL in total.

## Test plan
- Reset then free-run (XLEN=32, RESET_PC=0): after rst drops, pc reads 0x0, 0x4, 0x8, 0xC and pc_rom_addr reads 0, 1, 2, 3.
- Pause: pause held high for 3 cycles at pc=0x10, then pc advances to 0x14 on the first edge after pause drops.
- Redirect during pause: pause high, redirect_pc=0x100 and then 0x200 in consecutive cycles.
  - pend_valid goes 1 and pc stays at 0x10.
  - On pause release pc goes to 0x200, then 0x204, and pend_valid returns to 0.
- Trap priority: trap_valid with trap_pc=0x80, redirect_valid with 0x300, and pause all high in the same cycle.
  - pc goes to 0x80 next cycle; no pending target; pend_valid stays 0.
- Misalign and wrap:
  - redirect_pc=0x102 → pc=0x100 and misalign_err pulses high for exactly one cycle.
  - pc=0xFFFF_FFFC free-running → next pc=0x0.
- Reset mid-HOLD: pending target 0x400 stored, rst asserted one cycle → pc=RESET_PC, pend_valid=0, and 0x400 is never loaded.
